// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg : shared encodings and reset constants for pipe_reg_file
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

  typedef enum logic [1:0] {
    SP_HOLD = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_LOAD = 2'b11
  } sp_op_e;

  localparam logic [31:0] DEF_SP_TOP   = 32'd2047;
  localparam logic [31:0] DEF_PC_RESET = 32'd32;

endpackage

`default_nettype wire

// File: rtl/stack_ptr_unit.sv
// ============================================================================
// stack_ptr_unit : downward-growing stack pointer with bound guards and
//                  a sticky overflow/underflow fault.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stack_ptr_unit
  import reg_file_pkg::*;
#(
  parameter logic [31:0] SP_TOP    = DEF_SP_TOP,
  parameter logic [31:0] SP_BOTTOM = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sp_op,
  input  logic [31:0] sp_wdata,
  output logic [31:0] sp,
  output logic        sp_fault
);

  logic [31:0] sp_d, sp_q;
  logic        fault_d, fault_q;

  always_comb begin
    sp_d    = sp_q;
    fault_d = fault_q;
    case (sp_op_e'(sp_op))
      SP_PUSH: begin
        if (sp_q > SP_BOTTOM) sp_d = sp_q - 32'd1;
        else                  fault_d = 1'b1;
      end
      SP_POP: begin
        if (sp_q < SP_TOP) sp_d = sp_q + 32'd1;
        else               fault_d = 1'b1;
      end
      // Load is unchecked and is the only way (besides reset) to clear the fault.
      SP_LOAD: begin
        sp_d    = sp_wdata;
        fault_d = 1'b0;
      end
      default: ;
    endcase
    if (rst) begin
      sp_d    = SP_TOP;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    sp_q    <= sp_d;
    fault_q <= fault_d;
  end

  assign sp       = sp_q;
  assign sp_fault = fault_q;

endmodule

`default_nettype wire

// File: rtl/pipe_reg_file.sv
// ============================================================================
// pipe_reg_file : architectural register file (GPRs with write-first bypass,
//                 guarded SP, PC, masked CCR) for the five-stage pipeline.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_reg_file
  import reg_file_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          NUM_REGS  = 8,
  parameter int          AW        = 3,
  parameter int          NUM_RD    = 2,
  parameter int          CCR_W     = 4,
  parameter logic [31:0] SP_TOP    = DEF_SP_TOP,
  parameter logic [31:0] SP_BOTTOM = 32'd0,
  parameter logic [31:0] PC_RESET  = DEF_PC_RESET,
  parameter int          BYPASS    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [1:0]               sp_op,
  input  logic [31:0]              sp_wdata,
  output logic [31:0]              sp,
  output logic                     sp_fault,
  input  logic                     pc_load,
  input  logic                     pc_inc,
  input  logic [1:0]               pc_step,
  input  logic [31:0]              pc_wdata,
  output logic [31:0]              pc,
  input  logic [CCR_W-1:0]         ccr_mask,
  input  logic [CCR_W-1:0]         ccr_wdata,
  output logic [CCR_W-1:0]         ccr
);

  logic [DATA_W-1:0] gpr_d [NUM_REGS];
  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [31:0]       pc_d, pc_q;
  logic [CCR_W-1:0]  ccr_d, ccr_q;
  logic              wr_hit;

  assign wr_hit = wr_en && (32'(wr_addr) < NUM_REGS);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      gpr_d[i] = rst ? '0 : gpr_q[i];
    end
    if (!rst && wr_hit) gpr_d[wr_addr] = wr_data;
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_load)     pc_d = pc_wdata;
    else if (pc_inc) pc_d = pc_q + {30'd0, pc_step};
    if (rst)         pc_d = PC_RESET;
  end

  always_comb begin
    ccr_d = (ccr_q & ~ccr_mask) | (ccr_wdata & ccr_mask);
    if (rst) ccr_d = '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= gpr_d[i];
    pc_q  <= pc_d;
    ccr_q <= ccr_d;
  end

  // Write-first forwarding lets decode see a write-back in the same cycle.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[k*AW +: AW];
    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = '0;
      if (32'(addr) < NUM_REGS) begin
        if ((BYPASS != 0) && wr_en && (wr_addr == addr))
          rd_data[k*DATA_W +: DATA_W] = wr_data;
        else
          rd_data[k*DATA_W +: DATA_W] = gpr_q[addr];
      end
    end
  end

  stack_ptr_unit #(
    .SP_TOP    (SP_TOP),
    .SP_BOTTOM (SP_BOTTOM)
  ) u_sp (
    .clk      (clk),
    .rst      (rst),
    .sp_op    (sp_op),
    .sp_wdata (sp_wdata),
    .sp       (sp),
    .sp_fault (sp_fault)
  );

  assign pc  = pc_q;
  assign ccr = ccr_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_file.sv
// ============================================================================
// tb_pipe_reg_file : directed bench for pipe_reg_file with a reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_reg_file;
  import reg_file_pkg::*;

  localparam int DW = 16;
  localparam int NR = 6;
  localparam int AW = 3;
  localparam int RD = 2;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [RD*AW-1:0]  rd_addr;
  logic [RD*DW-1:0]  rd_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [1:0]        sp_op;
  logic [31:0]       sp_wdata;
  logic [31:0]       sp;
  logic              sp_fault;
  logic              pc_load;
  logic              pc_inc;
  logic [1:0]        pc_step;
  logic [31:0]       pc_wdata;
  logic [31:0]       pc;
  logic [CW-1:0]     ccr_mask;
  logic [CW-1:0]     ccr_wdata;
  logic [CW-1:0]     ccr;

  int total = 0;
  int bad   = 0;

  pipe_reg_file #(
    .DATA_W(DW), .NUM_REGS(NR), .AW(AW), .NUM_RD(RD), .CCR_W(CW),
    .SP_TOP(32'd2047), .SP_BOTTOM(32'd0), .PC_RESET(32'd32), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sp_op(sp_op), .sp_wdata(sp_wdata), .sp(sp), .sp_fault(sp_fault),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_step(pc_step), .pc_wdata(pc_wdata),
    .pc(pc), .ccr_mask(ccr_mask), .ccr_wdata(ccr_wdata), .ccr(ccr)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state as plain variables.
  logic [DW-1:0] m_gpr [NR];
  logic [31:0]   m_sp, m_pc;
  logic          m_fault;
  logic [CW-1:0] m_ccr;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) m_gpr[i] = '0;
      m_sp = 2047; m_pc = 32; m_fault = 1'b0; m_ccr = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (wr_en && int'(wr_addr) < NR) m_gpr[wr_addr] = wr_data;
      case (sp_op)
        2'b01: if (m_sp == 0) m_fault = 1'b1; else m_sp = m_sp - 1;
        2'b10: if (m_sp >= 2047) m_fault = 1'b1; else m_sp = m_sp + 1;
        2'b11: begin m_sp = sp_wdata; m_fault = 1'b0; end
        default: ;
      endcase
      if (pc_load)     m_pc = pc_wdata;
      else if (pc_inc) m_pc = m_pc + 32'(pc_step);
      for (int i = 0; i < CW; i++) if (ccr_mask[i]) m_ccr[i] = ccr_wdata[i];
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (int'(a) >= NR)             return '0;
    if (wr_en && wr_addr == a)     return wr_data;
    return m_gpr[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid && !rst) begin
      for (int k = 0; k < RD; k++)
        check($sformatf("model_rd%0d", k), 64'(rd_data[k*DW +: DW]),
              64'(exp_rd(rd_addr[k*AW +: AW])));
      check("model_sp", 64'(sp), 64'(m_sp));
      check("model_fault", 64'(sp_fault), 64'(m_fault));
      check("model_pc", 64'(pc), 64'(m_pc));
      check("model_ccr", 64'(ccr), 64'(m_ccr));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sp_op = SP_HOLD; sp_wdata = '0; pc_load = 1'b0; pc_inc = 1'b0;
    pc_step = '0; pc_wdata = '0; ccr_mask = '0; ccr_wdata = '0;
    cycle();
    rst = 1'b0;
    set_rd(0, 3'd0); set_rd(1, 3'd1);
    #1;
    check("reset_sp", 64'(sp), 64'd2047);
    check("reset_pc", 64'(pc), 64'd32);
    check("reset_ccr", 64'(ccr), 64'd0);
    check("reset_fault", 64'(sp_fault), 64'd0);
    check("reset_rd0", 64'(rd(0)), 64'd0);
    check("reset_rd1", 64'(rd(1)), 64'd0);

    // Write with same-cycle bypass
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; set_rd(0, 3'd3);
    #1 check("bypass_rd0", 64'(rd(0)), 64'hBEEF);
    cycle();
    wr_en = 1'b0;
    #1 check("written_rd0", 64'(rd(0)), 64'hBEEF);

    // Out-of-range write/read
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1234; set_rd(1, 3'd7);
    #1 check("oor_bypass_rd1", 64'(rd(1)), 64'd0);
    cycle();
    wr_en = 1'b0; set_rd(1, 3'd6);
    #1 check("oor_rd6", 64'(rd(1)), 64'd0);

    // Fill all registers, read back pairs
    for (int i = 0; i < NR; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'(16'h1111 * (i + 1));
      cycle();
    end
    wr_en = 1'b0;
    for (int i = 0; i < NR; i += 2) begin
      set_rd(0, 3'(i)); set_rd(1, 3'(i + 1));
      cycle();
    end
    set_rd(0, 3'd5);
    #1 check("fill_rd5", 64'(rd(0)), 64'h6666);

    // Stack bounds
    sp_op = SP_POP; cycle(); sp_op = SP_HOLD;
    check("pop_top_sp", 64'(sp), 64'd2047);
    check("pop_top_fault", 64'(sp_fault), 64'd1);
    sp_op = SP_LOAD; sp_wdata = 32'd5; cycle(); sp_op = SP_HOLD;
    check("load_sp", 64'(sp), 64'd5);
    check("load_fault", 64'(sp_fault), 64'd0);
    sp_op = SP_PUSH;
    repeat (5) cycle();
    check("push5_sp", 64'(sp), 64'd0);
    check("push5_fault", 64'(sp_fault), 64'd0);
    cycle(); sp_op = SP_HOLD;
    check("push_bottom_sp", 64'(sp), 64'd0);
    check("push_bottom_fault", 64'(sp_fault), 64'd1);
    sp_op = SP_POP; cycle(); sp_op = SP_HOLD;
    check("pop_sticky_sp", 64'(sp), 64'd1);
    check("pop_sticky_fault", 64'(sp_fault), 64'd1);

    // PC wrap and priority
    pc_load = 1'b1; pc_wdata = 32'hFFFF_FFFE; cycle();
    pc_load = 1'b0; pc_inc = 1'b1; pc_step = 2'd2; cycle();
    pc_inc = 1'b0;
    check("pc_wrap", 64'(pc), 64'd0);
    pc_load = 1'b1; pc_inc = 1'b1; pc_step = 2'd3; pc_wdata = 32'd100; cycle();
    pc_load = 1'b0;
    check("pc_priority", 64'(pc), 64'd100);
    cycle(); pc_inc = 1'b0;
    check("pc_inc3", 64'(pc), 64'd103);
    cycle();
    check("pc_hold", 64'(pc), 64'd103);

    // CCR masking
    ccr_mask = 4'b0101; ccr_wdata = 4'b1111; cycle();
    check("ccr_set", 64'(ccr), 64'b0101);
    ccr_mask = 4'b0001; ccr_wdata = 4'b0000; cycle();
    ccr_mask = 4'b0000; ccr_wdata = 4'b1111;
    check("ccr_clear", 64'(ccr), 64'b0100);
    cycle();
    check("ccr_hold", 64'(ccr), 64'b0100);

    // Reset wins over same-cycle push and write
    rst = 1'b1; sp_op = SP_PUSH; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5555;
    cycle();
    rst = 1'b0; sp_op = SP_HOLD; wr_en = 1'b0; set_rd(0, 3'd2);
    #1;
    check("rst_mid_sp", 64'(sp), 64'd2047);
    check("rst_mid_fault", 64'(sp_fault), 64'd0);
    check("rst_mid_gpr2", 64'(rd(0)), 64'd0);
    check("rst_mid_pc", 64'(pc), 64'd32);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_reg_file.md
Name: pipe_reg_file

Overview:
- Parametrised architectural register file for the five-stage pipeline.
- Provides NUM_RD combinational read ports with write-first bypass and one write port, plus a guarded stack pointer with push/pop/load and sticky fault, a 32-bit PC with load/increment, and a per-flag masked CCR.
- Decode reads it; write-back writes GPRs; execute/memory drive SP and CCR; fetch drives PC.

Parameters:
- DATA_W, 16, GPR width
- NUM_REGS, 8, GPR count
- AW, 3, GPR address width (2**AW >= NUM_REGS)
- NUM_RD, 2, number of read ports
- CCR_W, 4, condition flag count
- SP_TOP, 2047, SP reset value and highest legal SP
- SP_BOTTOM, 0, lowest legal SP
- PC_RESET, 32, PC reset value
- BYPASS, 1, 1 = same-cycle write forwarded to reads

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NUM_RD*AW  packed read addresses, port k at [k*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
- wr_en  in  1  GPR write enable
- wr_addr  in  AW  GPR write address
- wr_data  in  DATA_W  GPR write data
- sp_op  in  2  00 hold, 01 push (SP-=1), 10 pop (SP+=1), 11 load
- sp_wdata  in  32  SP load value
- sp  out  32  current SP
- sp_fault  out  1  sticky stack overflow/underflow flag
- pc_load  in  1  load PC from pc_wdata
- pc_inc  in  1  PC += pc_step
- pc_step  in  2  increment amount 0..3
- pc_wdata  in  32  PC load value
- pc  out  32  current PC
- ccr_mask  in  CCR_W  per-flag write enable
- ccr_wdata  in  CCR_W  flag data
- ccr  out  CCR_W  current flags

Behaviour:
- Reset (rst=1 at clk edge):
  - All GPRs = 0; SP = SP_TOP; PC = PC_RESET; CCR = 0; sp_fault = 0.
  - During reset all other inputs are ignored, including in the same cycle.
  - Reset mid-push/pop simply wins.
- Reads are combinational:
  - rd_data[k] = GPR[rd_addr[k]].
  - If rd_addr[k] >= NUM_REGS, rd_data[k] = 0.
  - If BYPASS=1 and wr_en and wr_addr==rd_addr[k] (in range), rd_data[k] = wr_data in the same cycle.
  - If BYPASS=0, old contents are returned until the edge.
- GPR write: on edge when wr_en and wr_addr < NUM_REGS. Out-of-range writes are dropped silently. Write latency is 1 cycle.
- SP (32-bit, stack grows downward):
  - push: if SP > SP_BOTTOM then SP-1; else SP held and sp_fault set (overflow).
  - pop: if SP < SP_TOP then SP+1; else SP held and sp_fault set (underflow).
  - load: SP = sp_wdata unconditionally, and sp_fault cleared. No range check on load.
  - sp_fault stays set until load or rst; further push/pop still apply their guards.
- PC:
  - pc_load has priority over pc_inc.
  - pc_inc: PC = PC + zero-extended pc_step, modulo 2^32 (0xFFFFFFFF + 1 -> 0).
  - Neither asserted: hold.
- CCR: each bit i updates to ccr_wdata[i] iff ccr_mask[i]; unmasked bits hold. No read-bypass on CCR; ccr shows the registered value.
- All state outputs (sp, pc, ccr, sp_fault) are registered; 1-cycle update latency.

Decomposition:
- Shared package reg_file_pkg:
  - sp_op encodings SP_HOLD=2'b00, SP_PUSH=2'b01, SP_POP=2'b10, SP_LOAD=2'b11
  - default SP_TOP / PC_RESET constants
- Sub-module stack_ptr_unit: SP register, bound guards and sticky fault. Parameters SP_TOP and SP_BOTTOM; ports clk, rst, sp_op, sp_wdata, sp, sp_fault.
- GPR array, PC and CCR remain in the top module.

Test Plan:
- Reset then read: rst=1 for 1 cycle -> sp=2047, pc=32, ccr=0, sp_fault=0, all rd_data=0.
- Write/bypass: wr_en=1, wr_addr=3, wr_data=16'hBEEF, rd_addr port0=3 same cycle -> rd_data0=16'hBEEF before the edge (BYPASS=1). Next cycle with wr_en=0 -> still 16'hBEEF. Out-of-range: wr_addr=7 with NUM_REGS=6 -> no change; rd of address 7 returns 0.
- Stack bounds: after reset, pop -> sp stays 2047, sp_fault=1. Load 5 -> sp=5, fault=0. Push x5 -> sp=0. Push -> sp=0, fault=1.
- PC: pc_load=1, pc_wdata=32'hFFFFFFFE, then pc_inc with pc_step=2 -> pc=0. pc_load and pc_inc together with pc_wdata=100 -> pc=100.
- CCR mask: ccr=0, mask=4'b0101, wdata=4'b1111 -> ccr=4'b0101. Then mask=4'b0001, wdata=0 -> ccr=4'b0100.
- Reset mid-operation: push plus wr_en to reg 2 in the same cycle as rst=1 -> sp=2047, GPR2=0, fault=0.
